cache_controller: RTL

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller.sv | 128 ++++++++++++
 1 files changed

// File: rtl/cache_controller.sv
// Blocking read-only cache controller: looks up one word, fills a whole
// line from memory on a miss, and reports hit/miss statistics.
module cache_controller #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpuRd,
  input  logic [14:0]  cpuAddr,
  output logic [31:0]  cpuData,
  output logic         cpuReady,
  output logic         cpuErr,
  output logic         busy,
  output logic [14:0]  cacheAddr,
  output logic         cacheWrEn,
  output logic [127:0] cacheLine,
  input  logic         cacheHit,
  input  logic [31:0]  cacheData,
  output logic         memRd,
  output logic [12:0]  memAddr,
  input  logic         memReady,
  input  logic [127:0] memData,
  output logic [15:0]  hitCount,
  output logic [15:0]  missCount
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS,
    FILL,
    RESPOND
  } state_t;

  state_t              state, state_nxt;
  logic [14:0]         addr_reg;
  logic [127:0]        line_reg;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                err_reg;
  logic                timeout;
  logic [31:0]         fill_word;

  // Last MISS cycle: the counter started at 0, so this is cycle MEM_TIMEOUT.
  assign timeout = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  // NOTE: async reset is in the sensitivity list so outputs drop immediately,
  // even mid-miss; state is decoded straight into the handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpuRd) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = cacheHit ? RESPOND : MISS;
      MISS: begin
        if (memReady)     state_nxt = FILL;
        else if (timeout) state_nxt = RESPOND;
      end
      FILL:    state_nxt = RESPOND;
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fill_word = line_reg[127:96];
    case (addr_reg[1:0])
      2'd1:    fill_word = line_reg[95:64];
      2'd2:    fill_word = line_reg[63:32];
      2'd3:    fill_word = line_reg[31:0];
      default: fill_word = line_reg[127:96];
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg  <= '0;
      line_reg  <= '0;
      wait_cnt  <= '0;
      err_reg   <= 1'b0;
      cpuData   <= '0;
      hitCount  <= '0;
      missCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          err_reg <= 1'b0;
          if (cpuRd) addr_reg <= cpuAddr;
        end
        LOOKUP: begin
          if (cacheHit) begin
            cpuData <= cacheData;
            if (hitCount != 16'hFFFF) hitCount <= hitCount + 16'd1;
          end else begin
            wait_cnt <= '0;
            if (missCount != 16'hFFFF) missCount <= missCount + 16'd1;
          end
        end
        MISS: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (memReady)     line_reg <= memData;
          else if (timeout) err_reg  <= 1'b1;
        end
        FILL:    cpuData <= fill_word;
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign memRd     = (state == MISS);
  assign cacheWrEn = (state == FILL);
  assign cpuReady  = (state == RESPOND);
  assign cpuErr    = (state == RESPOND) && err_reg;
  assign cacheAddr = addr_reg;
  assign memAddr   = addr_reg[14:2];
  assign cacheLine = line_reg;

endmodule
